// File: rtl/btn_cmd_arbiter.sv
// rtl/btn_cmd_arbiter.sv - debounced buttons with auto-repeat, arbitrated onto one command stream
// Each channel: sync -> debounce -> press/repeat FSM -> pending slot; a round-robin picker offers one event at a time.
module btn_cmd_arbiter #(
  parameter int unsigned            N_BUTTONS       = 4,
  parameter int unsigned            DEBOUNCE_CYCLES = 500000,
  parameter int unsigned            REPEAT_DELAY    = 50000000,
  parameter int unsigned            REPEAT_PERIOD   = 10000000,
  parameter logic [N_BUTTONS-1:0]   REPEAT_MASK     = '1,
  parameter logic [3*N_BUTTONS-1:0] CMD_MAP         = {3'd4, 3'd3, 3'd2, 3'd1}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] buttons,
  output logic [2:0]           cmd,
  output logic [31:0]          cmd_arg0,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           dropped
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PW = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1;
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]   DELAY_LAST  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0]   PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} ch_state_t;
  typedef enum logic {OFFER_IDLE, OFFER} out_state_t;

  logic [N_BUTTONS-1:0] sync1, sync2, db, evt, pending;
  logic [DW-1:0]        db_cnt   [N_BUTTONS];
  ch_state_t            ch_state [N_BUTTONS];
  logic [31:0]          timer    [N_BUTTONS];
  logic [31:0]          rep_idx  [N_BUTTONS];
  logic [31:0]          latched  [N_BUTTONS];
  out_state_t           out_state;
  logic [PW-1:0]        rr_ptr, next_ptr;
  logic [N_BUTTONS-1:0] sel_oh;
  logic                 sel_found, grant;
  logic [2:0]           sel_cmd;
  logic [31:0]          sel_arg;
  logic [8:0]           drop_sum, drop_total;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      evt   <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        db_cnt[i]   <= '0;
        ch_state[i] <= IDLE;
        timer[i]    <= '0;
        rep_idx[i]  <= '0;
      end
    end else begin
      sync1 <= buttons;
      sync2 <= sync1;
      for (int i = 0; i < N_BUTTONS; i++) begin
        evt[i] <= 1'b0;
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          db[i]     <= ~db[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
        // A debounced low always wins, so no repeat can fire once the release is accepted.
        if (!db[i]) begin
          ch_state[i] <= IDLE;
          timer[i]    <= '0;
        end else begin
          case (ch_state[i])
            IDLE: begin
              ch_state[i] <= HELD;
              timer[i]    <= '0;
              rep_idx[i]  <= '0;
              evt[i]      <= 1'b1;
            end
            HELD: begin
              if (REPEAT_MASK[i]) begin
                if (timer[i] == DELAY_LAST) begin
                  ch_state[i] <= REPEAT;
                  timer[i]    <= '0;
                  rep_idx[i]  <= (rep_idx[i] == 32'hFFFF_FFFF) ? rep_idx[i] : rep_idx[i] + 32'd1;
                  evt[i]      <= 1'b1;
                end else begin
                  timer[i] <= timer[i] + 32'd1;
                end
              end
            end
            REPEAT: begin
              if (timer[i] == PERIOD_LAST) begin
                timer[i]   <= '0;
                rep_idx[i] <= (rep_idx[i] == 32'hFFFF_FFFF) ? rep_idx[i] : rep_idx[i] + 32'd1;
                evt[i]     <= 1'b1;
              end else begin
                timer[i] <= timer[i] + 32'd1;
              end
            end
            default: ch_state[i] <= IDLE;
          endcase
        end
      end
    end
  end

  // First pass searches from rr_ptr upward, second pass wraps to the lowest channel.
  always_comb begin
    sel_found = 1'b0;
    sel_oh    = '0;
    sel_cmd   = '0;
    sel_arg   = '0;
    next_ptr  = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < N_BUTTONS; c++) begin
        if (!sel_found && pending[c] && (pass == 1 || c >= int'(rr_ptr))) begin
          sel_found = 1'b1;
          sel_oh[c] = 1'b1;
          sel_cmd   = CMD_MAP[3*c +: 3];
          sel_arg   = latched[c];
          next_ptr  = (c == N_BUTTONS - 1) ? '0 : PW'(c + 1);
        end
      end
    end
  end

  assign grant = (out_state == OFFER_IDLE) && sel_found;

  always_comb begin
    drop_sum = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (evt[i] && pending[i] && !(grant && sel_oh[i])) drop_sum = drop_sum + 9'd1;
    end
    drop_total = {1'b0, dropped} + drop_sum;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_state <= OFFER_IDLE;
      cmd       <= '0;
      cmd_arg0  <= '0;
      cmd_valid <= 1'b0;
      rr_ptr    <= '0;
      pending   <= '0;
      dropped   <= '0;
      for (int i = 0; i < N_BUTTONS; i++) latched[i] <= '0;
    end else begin
      // A new event beats the grant's clear, so an event in the selection cycle stays pending.
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (evt[i]) begin
          pending[i] <= 1'b1;
          latched[i] <= rep_idx[i];
        end else if (grant && sel_oh[i]) begin
          pending[i] <= 1'b0;
        end
      end
      dropped <= drop_total[8] ? 8'hFF : drop_total[7:0];
      case (out_state)
        OFFER_IDLE: begin
          if (sel_found) begin
            out_state <= OFFER;
            cmd       <= sel_cmd;
            cmd_arg0  <= sel_arg;
            cmd_valid <= 1'b1;
            rr_ptr    <= next_ptr;
          end
        end
        OFFER: begin
          if (cmd_ready) begin
            out_state <= OFFER_IDLE;
            cmd_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// tb/tb_btn_cmd_arbiter.sv - directed bench for btn_cmd_arbiter
module tb_btn_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  buttons = 4'h0;
  logic        cmd_ready = 1'b1;
  logic [2:0]  cmd;
  logic [31:0] cmd_arg0;
  logic        cmd_valid;
  logic [7:0]  dropped;

  int          n_checks = 0;
  int          n_pass = 0;
  int          edge_n = -1;
  int          valid_cycles = 0;
  logic        prev_valid = 1'b0;
  int          q_edge[$];
  logic [2:0]  q_cmd[$];
  logic [31:0] q_arg[$];

  always #5 clk = ~clk;

  btn_cmd_arbiter #(
    .N_BUTTONS      (4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .buttons  (buttons),
    .cmd      (cmd),
    .cmd_arg0 (cmd_arg0),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .dropped  (dropped)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance n edges, sampling 1 time unit after each and logging offer starts.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_n++;
      if (cmd_valid && !prev_valid) begin
        q_edge.push_back(edge_n);
        q_cmd.push_back(cmd);
        q_arg.push_back(cmd_arg0);
      end
      if (cmd_valid) valid_cycles++;
      prev_valid = cmd_valid;
    end
  endtask

  task automatic clear_log();
    q_edge.delete();
    q_cmd.delete();
    q_arg.delete();
    valid_cycles = 0;
    prev_valid = 1'b0;
    edge_n = -1;
  endtask

  task automatic restart(input logic [3:0] b);
    rst_n = 1'b0;
    buttons = 4'h0;
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
    buttons = b;
  endtask

  task automatic check_offer(input string sc, input int i, input int e, input logic [2:0] c, input logic [31:0] a);
    if (i < q_edge.size()) begin
      check_eq($sformatf("%s offer%0d edge", sc, i), q_edge[i], e);
      check_eq($sformatf("%s offer%0d cmd", sc, i), {29'd0, q_cmd[i]}, {29'd0, c});
      check_eq($sformatf("%s offer%0d arg0", sc, i), q_arg[i], a);
    end else begin
      check_eq($sformatf("%s offer%0d present", sc, i), q_edge.size(), i + 1);
    end
  endtask

  initial begin
    buttons = 4'hF;
    step(3);
    check_eq("reset cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check_eq("reset cmd", {29'd0, cmd}, 32'd0);
    check_eq("reset cmd_arg0", cmd_arg0, 32'd0);
    check_eq("reset dropped", {24'd0, dropped}, 32'd0);

    // Single press on channel 1.
    restart(4'b0010);
    step(9);
    buttons = 4'h0;
    step(30);
    check_eq("press count", q_edge.size(), 1);
    check_offer("press", 0, 8, 3'd2, 32'd0);
    check_eq("press valid cycles", valid_cycles, 1);
    check_eq("press dropped", {24'd0, dropped}, 32'd0);

    // Three-cycle glitch is one short of the debounce window.
    restart(4'b0010);
    step(3);
    buttons = 4'h0;
    step(30);
    check_eq("glitch count", q_edge.size(), 0);
    check_eq("glitch dropped", {24'd0, dropped}, 32'd0);

    // Long hold on channel 0: press plus five repeats.
    restart(4'b0001);
    step(35);
    buttons = 4'h0;
    step(25);
    check_eq("repeat count", q_edge.size(), 6);
    check_offer("repeat", 0, 8, 3'd1, 32'd0);
    check_offer("repeat", 1, 18, 3'd1, 32'd1);
    check_offer("repeat", 2, 23, 3'd1, 32'd2);
    check_offer("repeat", 3, 28, 3'd1, 32'd3);
    check_offer("repeat", 4, 33, 3'd1, 32'd4);
    check_offer("repeat", 5, 38, 3'd1, 32'd5);
    check_eq("repeat valid cycles", valid_cycles, 6);

    // All four together: round-robin from channel 0.
    restart(4'hF);
    step(9);
    buttons = 4'h0;
    step(20);
    check_eq("rr count", q_edge.size(), 4);
    check_offer("rr", 0, 8, 3'd1, 32'd0);
    check_offer("rr", 1, 10, 3'd2, 32'd0);
    check_offer("rr", 2, 12, 3'd3, 32'd0);
    check_offer("rr", 3, 14, 3'd4, 32'd0);
    check_eq("rr valid cycles", valid_cycles, 4);

    // Backpressure on channel 2 across three repeats.
    restart(4'b0100);
    cmd_ready = 1'b0;
    step(25);
    buttons = 4'h0;
    step(4);
    check_eq("bp cmd_valid held", {31'd0, cmd_valid}, 32'd1);
    check_eq("bp cmd", {29'd0, cmd}, 32'd3);
    check_eq("bp cmd_arg0", cmd_arg0, 32'd0);
    check_eq("bp dropped", {24'd0, dropped}, 32'd2);
    check_eq("bp valid cycles", valid_cycles, 21);
    check_eq("bp offers while held", q_edge.size(), 1);
    cmd_ready = 1'b1;
    step(22);
    check_eq("bp total offers", q_edge.size(), 2);
    check_offer("bp", 1, 30, 3'd3, 32'd3);
    check_eq("bp dropped after", {24'd0, dropped}, 32'd2);

    // Reset asserted mid-offer.
    restart(4'b0010);
    step(9);
    check_eq("midreset valid before", {31'd0, cmd_valid}, 32'd1);
    rst_n = 1'b0;
    buttons = 4'h0;
    #1;
    check_eq("midreset valid async", {31'd0, cmd_valid}, 32'd0);
    check_eq("midreset cmd", {29'd0, cmd}, 32'd0);
    step(2);
    rst_n = 1'b1;
    clear_log();
    step(30);
    check_eq("midreset no offer", q_edge.size(), 0);

    // Button held across reset release gives exactly one press.
    rst_n = 1'b0;
    buttons = 4'b0001;
    step(2);
    rst_n = 1'b1;
    clear_log();
    step(9);
    buttons = 4'h0;
    step(20);
    check_eq("held-reset count", q_edge.size(), 1);
    check_offer("held-reset", 0, 8, 3'd1, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
